addsub_serial_seq: RTL and testbench

//  Sequences one shared 4-bit add/sub slice (b XOR mode, carry-in = mode) over WIDTH/4 cycles.

---
 rtl/addsub_serial_seq.sv | 153 +++++++++++++++
 tb/tb_addsub_serial_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_seq.sv
// Serial WIDTH-bit add/subtract: one shared 4-bit slice, sequenced over WIDTH/4 cycles,
// least-significant nibble first, with valid/ready on both the request and result sides.

module addsub_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    logic [3:0] bx;
    logic [3:0] low;

    always_comb begin
        bx          = b ^ {4{mode}};
        {cout, sum} = {1'b0, a} + {1'b0, bx} + {4'b0, cin};
        // carry into bit 3 feeds the signed-overflow flag on the last slice
        low         = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b0, cin};
        c3          = low[3];
    end

endmodule

module addsub_serial_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             mode_q;
    logic             carry_q;
    logic             co_q;
    logic             ov_q;
    logic [IW-1:0]    idx_q;

    logic [IW+1:0] bit_base;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    sum_nib;
    logic          c_out;
    logic          c_msb_in;
    logic          accept;
    logic          last;
    logic          retire;

    always_comb begin
        bit_base = {idx_q, 2'b00};
        a_nib    = a_q[bit_base +: 4];
        b_nib    = b_q[bit_base +: 4];
    end

    addsub_nibble_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .mode (mode_q),
        .cin  (carry_q),
        .sum  (sum_nib),
        .cout (c_out),
        .c3   (c_msb_in)
    );

    assign last   = (idx_q == IW'(N - 1));
    assign accept = (state_q == IDLE) && req_valid;
    assign retire = (state_q == DONE) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            mode_q  <= mode;
            carry_q <= mode;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            result_q[bit_base +: 4] <= sum_nib;
            carry_q <= c_out;
            if (last) begin
                co_q  <= c_out;
                ov_q  <= c_msb_in ^ c_out;
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;

    logic unused_retire;
    assign unused_retire = retire;

endmodule

// File: tb/tb_addsub_serial_seq.sv
// Randomized and directed bench for addsub_serial_seq (WIDTH=16)
// against a plain-arithmetic reference model.

module tb_addsub_serial_seq;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mode = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    // reference: full-width arithmetic, signed overflow from operand/result signs
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic m);
        int unsigned ai, bi, full;
        logic [W-1:0] r;
        logic co, ov;
        ai = int'(a);
        bi = int'(b);
        if (m) full = ai + (32'h10000 - bi);
        else   full = ai + bi;
        r  = full[W-1:0];
        co = full[W];
        if (m) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else   ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        return {co, ov, r};
    endfunction

    // drives one request and waits (bounded) for res_valid; leaves the result pending
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, output int lat, output bit to);
        req_valid = 1'b1;
        op_a = a;
        op_b = b;
        mode = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        mode = 1'($urandom);
        lat = 0;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (res_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic m);
        int lat;
        bit to;
        logic [W+1:0] exp;
        exp = model(a, b, m);
        run_op(a, b, m, lat, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s timeout: res_valid never rose", nm);
        end
        tests++;
        if (lat !== N) begin
            fails++;
            $display("FAIL %s latency got %0d want %0d", nm, lat, N);
        end
        tests++;
        if (result !== exp[W-1:0]) begin
            fails++;
            $display("FAIL %s result a=%h b=%h m=%0b got %h want %h",
                     nm, a, b, m, result, exp[W-1:0]);
        end
        tests++;
        if (carry_out !== exp[W+1]) begin
            fails++;
            $display("FAIL %s carry_out a=%h b=%h m=%0b got %0b want %0b",
                     nm, a, b, m, carry_out, exp[W+1]);
        end
        tests++;
        if (overflow !== exp[W]) begin
            fails++;
            $display("FAIL %s overflow a=%h b=%h m=%0b got %0b want %0b",
                     nm, a, b, m, overflow, exp[W]);
        end
        release_result();
    endtask

    task automatic check_idle(input string nm);
        tests++;
        if ({req_ready, res_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL %s flags rdy/vld/busy got %b want 100", nm,
                     {req_ready, res_valid, busy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        tests++;
        if ({result, carry_out, overflow} !== '0) begin
            fails++;
            $display("FAIL reset outputs got %h/%0b/%0b want 0/0/0",
                     result, carry_out, overflow);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        // golden values written out as well as cross-checked by the model
        tests++;
        if (model(16'h1234, 16'h0FFF, 1'b0) !== {2'b00, 16'h2233}
            || model(16'h0005, 16'h0007, 1'b1) !== {2'b00, 16'hFFFE}
            || model(16'h7FFF, 16'h0001, 1'b0) !== {2'b01, 16'h8000}
            || model(16'hFFFF, 16'h0001, 1'b0) !== {2'b10, 16'h0000}
            || model(16'h8000, 16'h0001, 1'b1) !== {2'b11, 16'h7FFF}
            || model(16'h0000, 16'h0000, 1'b1) !== {2'b10, 16'h0000}) begin
            fails++;
            $display("FAIL model_golden reference disagrees with known vectors");
        end
        check_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0);
        check_op("sub_5_7", 16'h0005, 16'h0007, 1'b1);
        check_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0);
        check_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0);
        check_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1);
        check_op("sub_0_0", 16'h0000, 16'h0000, 1'b1);
        tests++;
        if (result !== 16'h0000) begin
            fails++;
            $display("FAIL sub_0_0_direct got %h want 0000", result);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            check_op("random", W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        logic [W+1:0] exp;
        logic [W+1:0] exp2;
        logic [W-1:0] a2, b2;
        exp = model(16'hA5A5, 16'h1357, 1'b1);
        run_op(16'hA5A5, 16'h1357, 1'b1, lat, to);
        a2 = W'($urandom);
        b2 = W'($urandom);
        exp2 = model(a2, b2, 1'b0);
        req_valid = 1'b1;
        op_a = a2;
        op_b = b2;
        mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if ({res_valid, req_ready, busy} !== 3'b101
                || {carry_out, overflow, result} !== exp) begin
                fails++;
                $display("FAIL hold cyc%0d vld/rdy/busy=%b res=%h co=%0b ov=%0b want res=%h",
                         i, {res_valid, req_ready, busy}, result, carry_out,
                         overflow, exp[W-1:0]);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_idle("retire_only");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        tests++;
        if ({busy, req_ready} !== 2'b10) begin
            fails++;
            $display("FAIL accept_after_retire busy/rdy got %b want 10",
                     {busy, req_ready});
        end
        to = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (res_valid) begin
                to = 1'b0;
                break;
            end
        end
        tests++;
        if (to || lat != N || {carry_out, overflow, result} !== exp2) begin
            fails++;
            $display("FAIL queued_op to=%0b lat=%0d res=%h want %h",
                     to, lat, result, exp2[W-1:0]);
        end
        release_result();
    endtask

    task automatic test_reset_midrun();
        req_valid = 1'b1;
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        mode = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("midrun_reset");
        tests++;
        if (result !== '0) begin
            fails++;
            $display("FAIL midrun_reset result got %h want 0000", result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("post_reset");
        check_op("after_reset", 16'h4321, 16'h1111, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            check_op("b2b", W'($urandom), W'($urandom), 1'(i));
        check_idle("b2b_end");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
